mdu_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer for the MIPS ALU datapath. It accepts MULT/MULTU/DIV/DIVU from decode and runs an iterative radix-2 shift-add multiply or restoring divide over 32 cycles. Results are held in the HI/LO architectural registers. It raises busy so the pipeline stalls MFHI/MFLO and any new MDU op.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_step.sv | 32 +++
 rtl/mdu_sequencer.sv | 170 +++++++++++++++++
 tb/tb_mdu_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM state type and default operand width
// for the multiply/divide sequencer.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;

  // Bit 1 of the op selects divide, bit 0 clear means a signed op.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational radix-2 iteration on a 2*WIDTH+1 bit
// accumulator. Multiply: {hi_with_carry, multiplier}, conditional add then
// shift right. Divide: {remainder_with_carry, dividend/quotient}, shift left,
// trial subtract, set quotient bit.
module mdu_step import mdu_pkg::*; #(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic [2*WIDTH:0]   acc_i,
  output logic [2*WIDTH:0]   acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_s;
  logic [WIDTH:0] diff;
  logic           ge;

  // Single iteration; both datapaths are evaluated and is_div_i picks one.
  always_comb begin
    sum   = acc_i[2*WIDTH:WIDTH] + {1'b0, operand_i & {WIDTH{acc_i[0]}}};
    rem_s = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    diff  = rem_s - {1'b0, operand_i};
    ge    = (rem_s >= {1'b0, operand_i});
    if (is_div_i) begin
      acc_o = ge ? {diff, acc_i[WIDTH-2:0], 1'b1} : {rem_s, acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Magnitudes are iterated for WIDTH cycles in RUN, signs are applied in FIX,
// HI/LO are written on entry to DONE (done pulses while in DONE).
// Optional macro MDU_MTHILO_EN adds hi_we/lo_we/wdata for MTHI/MTLO writes
// that are honoured only in IDLE and take priority over start.
// Handshake: start is a level sampled only in IDLE; busy is high in RUN/FIX;
// done is a one-cycle pulse in DONE with HI/LO already holding the result.
module mdu_sequencer import mdu_pkg::*; #(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
`ifdef MDU_MTHILO_EN
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
`endif
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [1:0]       dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  mdu_state_e         state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               in_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH:0]   step_acc;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot, rem, quot_fix, rem_fix;
  logic               mt_hi, mt_lo;
  logic [WIDTH-1:0]   mt_data;
  logic               unused_acc_msb;

`ifdef MDU_MTHILO_EN
  assign mt_hi   = hi_we;
  assign mt_lo   = lo_we;
  assign mt_data = wdata;
`else
  assign mt_hi   = 1'b0;
  assign mt_lo   = 1'b0;
  assign mt_data = '0;
`endif

  // Operand magnitudes for signed ops; unsigned ops pass straight through.
  assign in_signed = op_is_signed(op);
  assign mag_a     = (in_signed && A[WIDTH-1]) ? -A : A;
  assign mag_b     = (in_signed && B[WIDTH-1]) ? -B : B;

  // Sign correction applied in FIX: product by sign xor, quotient by sign
  // xor, remainder follows the dividend. 0x80000000 / -1 wraps naturally.
  assign prod     = acc_q[2*WIDTH-1:0];
  assign prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
  assign quot     = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];
  assign quot_fix = (sign_a_q ^ sign_b_q) ? -quot : quot;
  assign rem_fix  = sign_a_q ? -rem : rem;
  assign unused_acc_msb = acc_q[2*WIDTH];

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i  (is_div_q),
    .operand_i (opnd_q),
    .acc_i     (acc_q),
    .acc_o     (step_acc)
  );

  // Next-state and datapath control; every register holds unless told otherwise.
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (mt_hi || mt_lo) begin
          if (mt_hi) hi_d = mt_data;
          if (mt_lo) lo_d = mt_data;
        end else if (start) begin
          is_div_d = op_is_div(op);
          sign_a_d = in_signed & A[WIDTH-1];
          sign_b_d = in_signed & B[WIDTH-1];
          cnt_d    = CNT_LOAD;
          if (op_is_div(op) && (B == '0)) begin
            hi_d    = A;
            lo_d    = '1;
            state_d = DONE;
          end else begin
            state_d = RUN;
            if (op_is_div(op)) begin
              acc_d  = {{(WIDTH+1){1'b0}}, mag_a};
              opnd_d = mag_b;
            end else begin
              acc_d  = {{(WIDTH+1){1'b0}}, mag_b};
              opnd_d = mag_a;
            end
          end
        end
      end
      RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy        = (state_q == RUN) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign HI          = hi_q;
  assign LO          = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed and random MULT/DIV ops against an arithmetic
// reference model; results are queued at issue and checked when done pulses.
module tb_mdu_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done;
  logic [W-1:0] HI, LO;
  logic [1:0]   dbg_state;
`ifdef MDU_MTHILO_EN
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [2*W-1:0] exp_q[$];
  int             cyc_q[$];
  logic [W-1:0]   last_hi = '0;
  logic [W-1:0]   last_lo = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mdu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
`ifdef MDU_MTHILO_EN
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
`endif
    .start       (start),
    .op          (op),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .HI          (HI),
    .LO          (LO),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (o)
      2'b00: p = sa * sb;
      2'b01: p = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          p  = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    int ec;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {HI, LO}, 64'd0);
        if ({HI, LO} == 64'd0) begin
          failures++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end
      end else begin
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        check("result_hilo", {HI, LO}, e);
        check("done_cycle", 64'(cyc), 64'(ec));
        last_hi = e[63:32];
        last_lo = e[31:0];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done) && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", {62'd0, busy, done}, 64'd0);
  endtask

  // mode 0: plain op; mode 1: extra start while busy; mode 2: start in DONE cycle
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int mode);
    int n, busy_cnt;
    bit div0;
    wait_idle();
    check("hold_hilo", {HI, LO}, {last_hi, last_lo});
    div0 = o[1] && (b == 0);
    op = o; A = a; B = b; start = 1'b1;
    exp_q.push_back(model(o, a, b));
    cyc_q.push_back(cyc + (div0 ? 1 : 34));
    @(negedge clk);
    start = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (!done && n < 60) begin
      if (busy) busy_cnt++;
      if (mode == 1) begin
        start = (n == 9);
        op = 2'($urandom); A = $urandom; B = $urandom;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("done_seen", {63'd0, done}, 64'd1);
    check("busy_cycles", 64'(busy_cnt), div0 ? 64'd0 : 64'd33);
    if (mode == 2) begin
      start = 1'b1; op = 2'b00; A = $urandom; B = $urandom;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        check("no_launch_from_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    int           rm, sel;

    repeat (3) @(negedge clk);
    #1;
    check("reset_state", {59'd0, dbg_state, busy, done}, 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'b11, 32'd7, 32'd2, 2);
    run_op(2'b11, 32'd7, 32'd0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'd6, 32'd7, 1);

    // reset aborts an op in flight
    wait_idle();
    op = 2'b00; A = 32'd6; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_flags", {59'd0, dbg_state, busy, done}, 64'd0);
    check("abort_hilo", {HI, LO}, 64'd0);
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", {62'd0, busy, done}, 64'd0);

`ifdef MDU_MTHILO_EN
    wait_idle();
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    last_hi = 32'h1234;
    check("mthi_idle", {HI, LO}, {last_hi, last_lo});
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    last_hi = 32'hABCD; last_lo = 32'hABCD;
    check("mthilo_both", {HI, LO}, {last_hi, last_lo});
    op = 2'b01; A = 32'd3; B = 32'd4; start = 1'b1;
    exp_q.push_back(model(2'b01, 32'd3, 32'd4));
    cyc_q.push_back(cyc + 34);
    @(negedge clk);
    start = 1'b0; hi_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_busy_ignored", {32'd0, HI}, {32'd0, last_hi});
    wait_idle();
    hi_we = 1'b1; wdata = 32'h5555; start = 1'b1; op = 2'b00; A = 32'd1; B = 32'd1;
    @(negedge clk);
    hi_we = 1'b0; start = 1'b0;
    last_hi = 32'h5555;
    check("mthi_beats_start", {31'd0, busy, HI}, {31'd0, 1'b0, last_hi});
    repeat (40) @(negedge clk);
`endif

    for (int k = 0; k < 20; k++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = '0;
      if (sel == 1) begin ra = 32'h8000_0000; rb = '1; end
      if (sel == 2) rb = 32'($urandom_range(1, 15));
      rm = $urandom_range(0, 2);
      if (ro[1] && rb == 0 && rm == 1) rm = 0;
      run_op(ro, ra, rb, rm);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
